serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor for the ULA: computes diff = a - b LSB-first, one bit per clock.
- Per-bit datapath is the half/full-subtractor equations (difference = x^y^borrow) with a registered borrow flip-flop between bits.
- Consumes operands from the register file/control; produces a full-width result, borrow-out and completion pulse for the ULA result mux.
- Start/done handshake; trades latency for minimal per-bit logic.

---
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Optional signed-overflow output ovf is built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, diff_sr_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             bw_q;
  logic [CW-1:0]    cnt_q;

  logic             x, y, d_bit, bw_next, last_bit, accept;

  assign x        = a_sr_q[0];
  assign y        = b_sr_q[0];
  assign d_bit    = x ^ y ^ bw_q;
  assign bw_next  = (~x & y) | (~(x ^ y) & bw_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign accept   = (state_q == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Operand shift registers, borrow flip-flop and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      bw_q      <= 1'b0;
      cnt_q     <= '0;
    end else if (accept) begin
      a_sr_q <= a;
      b_sr_q <= b;
      bw_q   <= 1'b0;
      cnt_q  <= '0;
    end else if (state_q == S_SHIFT) begin
      a_sr_q    <= {1'b0, a_sr_q[WIDTH-1:1]};
      b_sr_q    <= {1'b0, b_sr_q[WIDTH-1:1]};
      diff_sr_q <= {d_bit, diff_sr_q[WIDTH-1:1]};
      bw_q      <= bw_next;
      cnt_q     <= cnt_q + 1'b1;
    end
  end

  // Visible result only moves on the edge that retires the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if ((state_q == S_SHIFT) && last_bit) begin
      diff_q   <= {d_bit, diff_sr_q[WIDTH-1:1]};
      borrow_q <= bw_next;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, b_msb_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
    end else if ((state_q == S_SHIFT) && last_bit) begin
      ovf_q <= (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and table-driven checks for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] diff;
  logic       borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] last_d;
  logic       last_b;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [7:0] ed;
    logic       eb;
    logic       eo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Run one full operation, checking busy window, result hold, done timing and value.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic [7:0] ed,
                       input logic eb, input logic eo, input string tag);
    int bad_busy;
    int bad_hold;
    bad_busy = 0;
    bad_hold = 0;
    @(negedge clk);
    a = ta; b = tbv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = ~ta; b = ~tbv;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
      if (diff !== last_d || borrow !== last_b) bad_hold++;
    end
    @(negedge clk);
    chk({tag, "/done_hi"}, done, 1);
    chk({tag, "/busy_lo"}, busy, 0);
    chk({tag, "/diff"}, diff, ed);
    chk({tag, "/borrow"}, borrow, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "/ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation in %s", tag);
`endif
    @(negedge clk);
    chk({tag, "/done_width"}, done, 0);
    chk({tag, "/busy_window"}, bad_busy, 0);
    chk({tag, "/result_hold"}, bad_hold, 0);
    last_d = ed;
    last_b = eb;
  endtask

  initial begin
    int n_done;
    int done_at;
    logic [8:0] r9;
    logic [7:0] ra, rb, rd;
    logic       ro;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[7] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};
    vecs[8] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    vecs[9] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset/busy", busy, 0);
    chk("reset/done", done, 0);
    chk("reset/diff", diff, 8'h00);
    chk("reset/borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("reset/ovf", ovf, 0);
`endif
    rst = 1'b0;
    last_d = 8'h00;
    last_b = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, vecs[i].eo, $sformatf("vec%0d", i));
    end

    // Start re-pulsed mid-shift and during DONE must be ignored.
    do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "pre_ignore");
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    done_at = -1;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        done_at = c;
        chk("ignore/diff", diff, 8'h02);
        chk("ignore/borrow", borrow, 0);
      end
      if (c == 9) chk("ignore/busy_after_done", busy, 0);
      if (c == 10) chk("ignore/still_idle", busy, 0);
      if (c == 3 || c == 8) begin
        a = 8'hAA; b = 8'h11; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk("ignore/done_count", n_done, 1);
    chk("ignore/done_cycle", done_at, 8);
    last_d = 8'h02;
    last_b = 1'b0;

    // Synchronous reset on cycle 4 aborts without a done pulse.
    @(negedge clk);
    a = 8'h0F; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 4) begin
        chk("rstmid/busy", busy, 0);
        chk("rstmid/done", done, 0);
        chk("rstmid/diff", diff, 8'h00);
        chk("rstmid/borrow", borrow, 0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rstmid/ovf", ovf, 0);
`endif
      end
      if (done === 1'b1) n_done++;
      rst = (c == 3);
    end
    rst = 1'b0;
    chk("rstmid/no_done", n_done, 0);
    last_d = 8'h00;
    last_b = 1'b0;
    do_op(8'h0F, 8'h01, 8'h0E, 1'b0, 1'b0, "after_rst");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      r9 = {1'b0, ra} - {1'b0, rb};
      rd = r9[7:0];
      ro = (ra[7] != rb[7]) && (rd[7] != ra[7]);
      do_op(ra, rb, rd, r9[8], ro, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
